// File: rtl/jt900h_regs_pkg.sv
// jt900h_regs_pkg: shared constants, decode result type and lane helpers for
// the TLCS-900H banked register file.
//  - width codes (one-hot): W_BYTE, W_WORD, W_LONG
//  - RFP op codes: RFP_NONE, RFP_INC, RFP_DEC, RFP_LD
//  - long-register codes (addr[7:2]): REG_CUR, REG_PREV, REG_XIX..REG_XSP
//  - dec_t: {valid, physical index 0-19, byte-lane mask}
package jt900h_regs_pkg;

  localparam logic [2:0] W_NONE = 3'b000;
  localparam logic [2:0] W_BYTE = 3'b001;
  localparam logic [2:0] W_WORD = 3'b010;
  localparam logic [2:0] W_LONG = 3'b100;

  localparam logic [1:0] RFP_NONE = 2'd0;
  localparam logic [1:0] RFP_INC  = 2'd1;
  localparam logic [1:0] RFP_DEC  = 2'd2;
  localparam logic [1:0] RFP_LD   = 2'd3;

  localparam logic [5:0] REG_CUR  = 6'd16;
  localparam logic [5:0] REG_PREV = 6'd20;
  localparam logic [5:0] REG_XIX  = 6'd24;
  localparam logic [5:0] REG_XIY  = 6'd25;
  localparam logic [5:0] REG_XIZ  = 6'd26;
  localparam logic [5:0] REG_XSP  = 6'd27;

  // 16 banked slots (4 banks x 4 regs) followed by XIX, XIY, XIZ, XSP
  localparam int NPHYS = 20;

  typedef struct packed {
    logic       valid;
    logic [4:0] idx;
    logic [3:0] mask;
  } dec_t;

  // Byte lanes touched by an access; a width that is not one-hot touches none
  function automatic logic [3:0] lane_mask(input logic [2:0] w, input logic [1:0] ofs);
    case (w)
      W_BYTE:  return 4'b0001 << ofs;
      W_WORD:  return ofs[1] ? 4'b1100 : 4'b0011;
      W_LONG:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Right-align and zero-extend the addressed lanes of a long register
  function automatic logic [31:0] rd_align(input logic [31:0] v, input logic [2:0] w,
                                           input logic [1:0] ofs);
    case (w)
      W_BYTE:  return {24'h0, v[ofs*8 +: 8]};
      W_WORD:  return {16'h0, v[ofs[1]*16 +: 16]};
      W_LONG:  return v;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/jt900h_regs_dec.sv
// jt900h_regs_dec: maps a register code plus the current bank pointer to a
// physical register slot and the byte lanes the access covers.
//  addr  in  8   register code: [7:2] long register, [1:0] byte offset
//  width in  3   one-hot access width
//  rfp   in  2   bank pointer used for the current/previous bank aliases
//  dec   out     {valid, idx, mask}; valid=0 for reserved codes, banks
//                >= NBANK or a width that is not one-hot
module jt900h_regs_dec import jt900h_regs_pkg::*; #(
  parameter int NBANK = 4
) (
  input  logic [7:0] addr,
  input  logic [2:0] width,
  input  logic [1:0] rfp,
  output dec_t       dec
);

  logic [5:0] lreg;
  logic [1:0] bank;
  logic       banked;

  always_comb begin
    lreg   = addr[7:2];
    bank   = lreg[3:2];
    banked = 1'b0;
    dec    = '0;
    if (lreg < REG_CUR) begin
      banked = 1'b1;
    end else if (lreg < REG_PREV) begin
      bank   = rfp;
      banked = 1'b1;
    end else if (lreg < REG_XIX) begin
      bank   = rfp - 2'd1;   // wraps mod 4 regardless of NBANK
      banked = 1'b1;
    end
    if (banked) begin
      dec.valid = int'(bank) < NBANK;
      dec.idx   = {1'b0, bank, lreg[1:0]};
    end else if (lreg <= REG_XSP) begin
      dec.valid = 1'b1;
      dec.idx   = 5'd16 + {3'b0, lreg[1:0]};
    end
    dec.mask = lane_mask(width, addr[1:0]);
    if (dec.mask == 4'b0000) dec.valid = 1'b0;
  end

endmodule

// File: rtl/jt900h_regs.sv
// jt900h_regs: banked general-register file at the ALU write-back end.
// One write port (byte/word/long lane merge), two registered read ports with
// one cycle latency, the RFP bank pointer and XIX/XIY/XIZ/XSP.
//  clk, rst_n        clock, async active-low reset
//  cen               clock enable; everything holds when low
//  we, waddr, din    write width (one-hot), register code, right-aligned data
//  ra0/rw0, ra1/rw1  read code and width per port
//  rd0, rd1          registered read data, right-aligned, zero-extended
//  rfp_op, rfp_din   bank pointer op (none/INCF/DECF/LDF) and LDF operand
//  rfp               current bank
// Build option: JT900H_REGS_BYPASS_EN forwards a same-cycle write into a read
// of the same register; without it such a read sees the pre-write value.
module jt900h_regs import jt900h_regs_pkg::*; #(
  parameter logic [31:0] SP_RST = 32'h100,
  parameter int          NBANK  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic [2:0]  we,
  input  logic [7:0]  waddr,
  input  logic [31:0] din,
  input  logic [7:0]  ra0,
  input  logic [7:0]  ra1,
  input  logic [2:0]  rw0,
  input  logic [2:0]  rw1,
  output logic [31:0] rd0,
  output logic [31:0] rd1,
  input  logic [1:0]  rfp_op,
  input  logic [1:0]  rfp_din,
  output logic [1:0]  rfp
);

  localparam logic [1:0] BMASK = 2'(NBANK - 1);

  logic [NPHYS-1:0][31:0] regs;
  logic [31:0]            wdata;
  dec_t                   wdec;
  dec_t       [1:0]       rdec;
  logic [1:0][7:0]        ra;
  logic [1:0][2:0]        rw;
  logic [1:0][31:0]       rnext;
  logic [1:0][31:0]       rd_q;

  assign ra  = {ra1, ra0};
  assign rw  = {rw1, rw0};
  assign rd0 = rd_q[0];
  assign rd1 = rd_q[1];

  // Replicate narrow data across all lanes so each lane just picks its byte
  always_comb begin
    case (we)
      W_BYTE:  wdata = {4{din[7:0]}};
      W_WORD:  wdata = {2{din[15:0]}};
      default: wdata = din;
    endcase
  end

  jt900h_regs_dec #(.NBANK(NBANK)) u_wdec (
    .addr (waddr),
    .width(we),
    .rfp  (rfp),
    .dec  (wdec)
  );

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [31:0] cur;

    jt900h_regs_dec #(.NBANK(NBANK)) u_rdec (
      .addr (ra[p]),
      .width(rw[p]),
      .rfp  (rfp),
      .dec  (rdec[p])
    );

    always_comb begin
      cur = regs[rdec[p].idx];
`ifdef JT900H_REGS_BYPASS_EN
      if (wdec.valid && rdec[p].valid && wdec.idx == rdec[p].idx) begin
        for (int b = 0; b < 4; b++)
          if (wdec.mask[b]) cur[b*8 +: 8] = wdata[b*8 +: 8];
      end
`endif
      rnext[p] = rdec[p].valid ? rd_align(cur, rw[p], ra[p][1:0]) : 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPHYS; i++) regs[i] <= (i == NPHYS - 1) ? SP_RST : 32'h0;
      rd_q <= '0;
      rfp  <= 2'd0;
    end else if (cen) begin
      for (int b = 0; b < 4; b++)
        if (wdec.valid && wdec.mask[b]) regs[wdec.idx][b*8 +: 8] <= wdata[b*8 +: 8];
      rd_q <= rnext;
      case (rfp_op)
        RFP_INC: rfp <= (rfp + 2'd1) & BMASK;
        RFP_DEC: rfp <= (rfp - 2'd1) & BMASK;
        RFP_LD:  rfp <= rfp_din & BMASK;
        default: rfp <= rfp;
      endcase
    end
  end

endmodule

// File: tb/tb_jt900h_regs.sv
// tb_jt900h_regs: directed scenarios plus randomized traffic on jt900h_regs,
// compared every cycle against a word-level model of the register file.
module tb_jt900h_regs;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b0;
  logic [2:0]  we = '0;
  logic [7:0]  waddr = '0;
  logic [31:0] din = '0;
  logic [7:0]  ra0 = '0, ra1 = '0;
  logic [2:0]  rw0 = '0, rw1 = '0;
  logic [31:0] rd0, rd1;
  logic [1:0]  rfp_op = '0, rfp_din = '0;
  logic [1:0]  rfp;

  jt900h_regs #(.SP_RST(32'h100), .NBANK(NB)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .we(we), .waddr(waddr), .din(din),
    .ra0(ra0), .ra1(ra1), .rw0(rw0), .rw1(rw1), .rd0(rd0), .rd1(rd1),
    .rfp_op(rfp_op), .rfp_din(rfp_din), .rfp(rfp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned m_reg[20];   // 0..15 bank*4+reg, 16..19 XIX XIY XIZ XSP
  int          m_rfp;
  logic [31:0] m_rd0, m_rd1;

  function automatic bit onehot(input logic [2:0] w);
    return w == 3'd1 || w == 3'd2 || w == 3'd4;
  endfunction

  function automatic int resolve(input logic [7:0] a, input int r);
    int l, bank;
    l = int'(a) / 4;
    if (l < 16)      bank = l / 4;
    else if (l < 20) bank = r;
    else if (l < 24) bank = (r + 3) % 4;
    else if (l < 28) return 16 + (l - 24);
    else             return -1;
    if (bank >= NB) return -1;
    return bank * 4 + (l % 4);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [2:0] w, input logic [7:0] a);
    logic [31:0] m;
    int sh;
    case (w)
      3'd1: begin sh = int'(a[1:0]) * 8; m = 32'hFF << sh;
                  return (old & ~m) | ((d & 32'hFF) << sh); end
      3'd2: begin sh = a[1] ? 16 : 0; m = 32'hFFFF << sh;
                  return (old & ~m) | ((d & 32'hFFFF) << sh); end
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] v, input logic [2:0] w,
                                          input logic [7:0] a);
    case (w)
      3'd1:    return (v >> (int'(a[1:0]) * 8)) & 32'hFF;
      3'd2:    return (v >> (a[1] ? 16 : 0)) & 32'hFFFF;
      default: return v;
    endcase
  endfunction

  function automatic logic [31:0] m_port(input logic [7:0] a, input logic [2:0] w, input int wp);
    int p;
    logic [31:0] v;
    p = resolve(a, m_rfp);
    if (p < 0 || !onehot(w)) return 32'h0;
    v = m_reg[p];
`ifdef JT900H_REGS_BYPASS_EN
    if (p == wp) v = merge(v, din, we, waddr);
`endif
    return extract(v, w, a);
  endfunction

  task automatic m_reset();
    foreach (m_reg[i]) m_reg[i] = 0;
    m_reg[19] = 32'h100;
    m_rfp = 0;
    m_rd0 = 0;
    m_rd1 = 0;
  endtask

  // One clock: update the model from the inputs, then compare all outputs
  task automatic tick();
    int wp;
    logic [31:0] e0, e1;
    if (cen) begin
      wp = onehot(we) ? resolve(waddr, m_rfp) : -1;
      e0 = m_port(ra0, rw0, wp);
      e1 = m_port(ra1, rw1, wp);
      if (wp >= 0) m_reg[wp] = merge(m_reg[wp], din, we, waddr);
      case (rfp_op)
        2'd1: m_rfp = (m_rfp + 1) % NB;
        2'd2: m_rfp = (m_rfp + NB - 1) % NB;
        2'd3: m_rfp = int'(rfp_din) % NB;
        default: ;
      endcase
      m_rd0 = e0;
      m_rd1 = e1;
    end
    @(posedge clk);
    #1;
    check("rd0", rd0, m_rd0);
    check("rd1", rd1, m_rd1);
    check("rfp", {30'b0, rfp}, m_rfp[31:0]);
  endtask

  task automatic drive(input logic [2:0] w, input logic [7:0] wa, input logic [31:0] d,
                       input logic [7:0] a0, input logic [2:0] w0,
                       input logic [7:0] a1, input logic [2:0] w1,
                       input logic [1:0] op, input logic [1:0] od);
    we = w; waddr = wa; din = d; ra0 = a0; rw0 = w0; ra1 = a1; rw1 = w1;
    rfp_op = op; rfp_din = od;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    m_reset();
    check("rst_rd0", rd0, 32'h0);
    check("rst_rd1", rd1, 32'h0);
    check("rst_rfp", {30'b0, rfp}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [31:0] held;

  initial begin
    m_reset();
    #1;
    cen = 1'b1;
    // 1. reset and XSP reset value
    do_reset();
    drive(0, 0, 0, 8'h6C, 3'd4, 8'h00, 3'd0, 0, 0);
    tick();
    check("xsp_rst", rd0, 32'h100);

    // 2. lane merge
    drive(3'd4, 8'h00, 32'h11223344, 0, 0, 0, 0, 0, 0); tick();
    drive(3'd1, 8'h02, 32'h000000AA, 0, 0, 0, 0, 0, 0); tick();
    drive(3'd2, 8'h00, 32'h0000BEEF, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 8'h00, 3'd4, 8'h03, 3'd1, 0, 0); tick();
    check("merge_long", rd0, 32'h11AABEEF);
    check("merge_byte", rd1, 32'h11);

    // 3. banks
    drive(0, 0, 0, 0, 0, 0, 0, 2'd3, 2'd2); tick();
    check("ldf2", {30'b0, rfp}, 32'd2);
    drive(3'd4, 8'h44, 32'h5, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 8'h24, 3'd4, 0, 0, 0, 0); tick();
    check("bank2_xbc", rd0, 32'h5);
    drive(0, 0, 0, 0, 0, 0, 0, 2'd2, 0); tick();
    drive(0, 0, 0, 8'h44, 3'd4, 8'h54, 3'd4, 0, 0); tick();
    check("bank1_xbc", rd0, 32'h0);
    check("prev_xbc", rd1, 32'h0);

    // 4. wrap and write/RFP collision
    drive(0, 0, 0, 0, 0, 0, 0, 2'd3, 2'd3); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 2'd1, 0); tick();
    check("inc_wrap", {30'b0, rfp}, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 2'd2, 0); tick();
    check("dec_wrap", {30'b0, rfp}, 32'd3);
    drive(3'd4, 8'h40, 32'hDEAD0003, 0, 0, 0, 0, 2'd1, 0); tick();
    drive(0, 0, 0, 8'h30, 3'd4, 8'h00, 3'd4, 0, 0); tick();
    check("coll_old_bank", rd0, 32'hDEAD0003);

    // 5. same-cycle write/read of XIX
    drive(3'd4, 8'h60, 32'h1234, 0, 0, 0, 0, 0, 0); tick();
    drive(3'd4, 8'h60, 32'hCAFE, 8'h60, 3'd4, 8'h61, 3'd1, 0, 0); tick();
`ifdef JT900H_REGS_BYPASS_EN
    check("bypass", rd0, 32'hCAFE);
`else
    check("bypass", rd0, 32'h1234);
`endif

    // 6. reserved code and clock enable
    drive(3'd4, 8'hF0, 32'hFFFFFFFF, 8'hF0, 3'd4, 8'h60, 3'd4, 0, 0); tick();
    check("resv_rd", rd0, 32'h0);
    drive(0, 0, 0, 8'h60, 3'd4, 0, 0, 0, 0); tick();
    held = rd0;
    cen = 1'b0;
    drive(3'd4, 8'h60, 32'h99, 8'h00, 3'd4, 0, 0, 2'd1, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("cen_hold", rd0, held);
    end
    cen = 1'b1;
    drive(0, 0, 0, 8'h60, 3'd4, 0, 0, 0, 0); tick();
    check("cen_nowrite", rd0, held);

    // reset asserted with a write pending discards the write
    drive(3'd4, 8'h64, 32'h77, 0, 0, 0, 0, 2'd1, 0);
    do_reset();
    drive(0, 0, 0, 8'h64, 3'd4, 8'h6C, 3'd4, 0, 0); tick();
    check("rst_discard", rd0, 32'h0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cen = $urandom_range(0, 9) != 0;
      we = 3'($urandom_range(0, 7));
      waddr = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 111));
      din = $urandom;
      ra0 = ($urandom_range(0, 4) == 0) ? waddr : 8'($urandom_range(0, 119));
      ra1 = ($urandom_range(0, 4) == 0) ? waddr : 8'($urandom_range(0, 119));
      rw0 = 3'($urandom_range(0, 7));
      rw1 = 3'($urandom_range(0, 7));
      rfp_op = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0;
      rfp_din = 2'($urandom);
      if (i == 300) do_reset();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
